vehicle_detect_array: RTL and testbench
=======================================

# vehicle_detect_array

Multi-channel vehicle presence detector for the traffic light controller, the parametrised successor to the single-lane car sensor. Each lane's raw `detect` input is synchronised, sampled on the shared one-second strobe, and counted over a fixed window. A per-channel state machine with a hold-off period converts the window count into a debounced `car` presence flag consumed by the light sequencer.

## Interface
- `CHANNELS`, default 4: number of independent lanes (≥1).
- `WINDOW`, default 1024: samples per evaluation window (≥2).
- `THRESH`, default 256: minimum asserted samples in a window to declare presence (1..WINDOW).
- `THRESH_OFF`, default 128: release threshold, used only with `VDET_HYST_EN` (1..THRESH).
- `HOLD`, default 2: consecutive empty windows tolerated before clearing presence (0..15).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sample_en`  in  1  single-cycle sampling strobe (from the second timer).
- `clear`  in  1  synchronous window restart.
- `detect`  in  CHANNELS  raw loop-detector inputs, asynchronous to `clk`.
- `car`  out  CHANNELS  debounced presence per lane.
- `car_rise`  out  CHANNELS  one-cycle pulse when `car[i]` goes 0→1.
- `win_done`  out  1  one-cycle pulse at each window evaluation.

## Operation
- **Synchroniser.** Each `detect[i]` passes through a 2-flop synchroniser. Sampling uses the second flop (`ds[i]`).
- **Window counter.**
  - Range 0..WINDOW-1; increments on `sample_en`.
  - At WINDOW-1 with `sample_en`, it wraps to 0 and an evaluation occurs.
- **Hit counters.**
  - One per channel, width clog2(WINDOW+1); increments on `sample_en` when `ds[i]`=1. It cannot overflow.
  - The evaluation uses count + current sample (`ds[i]`) and compares it against the threshold. The counter is then reset to 0.
- **Hit rule.**
  - `hit[i]` = (eval_count ≥ THRESH).
- **Per-channel FSM** (states EMPTY, OCCUPIED, HOLDING); transitions occur only at evaluation:
  - EMPTY: hit → OCCUPIED, pulse `car_rise[i]`. !hit → stay.
  - OCCUPIED: hit → stay. !hit → HOLDING with `hold_cnt`=1, or → EMPTY directly if HOLD=0.
  - HOLDING: hit → OCCUPIED and `hold_cnt` cleared. !hit → `hold_cnt`+1; when `hold_cnt` reaches HOLD → EMPTY.
  - `car[i]` = 1 in OCCUPIED and HOLDING; 0 in EMPTY.
- **`clear`.**
  - Zeroes the window counter and all hit counters. FSM states, `hold_cnt` and `car` are unchanged.
  - Has priority over a coincident `sample_en`: that sample is discarded and no evaluation occurs.
- Channels are fully independent; all share one window counter and evaluate on the same edge.

## Timing
- Reset values:
  - `car`, `car_rise`, `win_done` = 0.
  - Synchronisers, window counter, hit counters and `hold_cnt` = 0.
  - All FSMs in EMPTY.
- `detect` → `ds`: 2 clk cycles. A `detect` change becomes visible to sampling on the 3rd rising edge.
- Evaluation edge = the edge where `sample_en`=1 and window count = WINDOW-1. On that edge, `car`, `car_rise` and `win_done` register; all three are visible the following cycle.
- `car_rise` and `win_done` are high for exactly one cycle.
- `sample_en` held high for several cycles counts one sample per cycle; no edge detection is applied.
- Reset mid-window discards partial counts. After release, the first evaluation occurs after a full WINDOW samples.

## Configuration
- `VDET_HYST_EN` defined: an EMPTY channel uses THRESH to enter OCCUPIED. OCCUPIED and HOLDING channels count as hit when eval_count ≥ THRESH_OFF.
- `VDET_HYST_EN` undefined: THRESH is used in all states and THRESH_OFF is ignored.

## Test plan
All scenarios use WINDOW=8, THRESH=4, HOLD=1, CHANNELS=2, unless stated otherwise.
- **Basic presence:** `detect[0]`=1 steady, 8 strobes → `car[0]`=1 and a `car_rise[0]` pulse coincident with `win_done`; `car[1]` stays 0.
- **Threshold boundary:** 3 of 8 samples high → `car` stays 0. 4 of 8 samples high (including the last sample) → `car`=1.
- **Hold-off:** occupied, then one empty window → `car` stays 1 (HOLDING). A second empty window → `car`=0. Empty, then hit → back to OCCUPIED with no `car_rise`.
- **HOLD=0:** occupied followed by one empty window → `car`=0 at that evaluation.
- **`clear` with `sample_en`:** assert `clear` on the 8th strobe → no `win_done`, counts restart, `car` unchanged.
- **Hysteresis (`VDET_HYST_EN`, THRESH_OFF=2):** occupied, then a window with 2 hits → stays OCCUPIED. A window with 1 hit → HOLDING. Without the macro, the same 2-hit window → HOLDING.

Source files
------------

// File: rtl/vehicle_detect_array.sv
// Multi-lane vehicle presence detector: synchronise, windowed sample count, debounce FSM per lane.
// Optional release hysteresis enabled by defining VDET_HYST_EN.
module vehicle_detect_array #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WINDOW     = 1024,
  parameter int unsigned THRESH     = 256,
  parameter int unsigned THRESH_OFF = 128,
  parameter int unsigned HOLD       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic                clear,
  input  logic [CHANNELS-1:0] detect,
  output logic [CHANNELS-1:0] car,
  output logic [CHANNELS-1:0] car_rise,
  output logic                win_done
);

  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1);
  localparam int unsigned HOLD_W = 4;

`ifdef VDET_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  localparam int unsigned REL_LVL = HYST_EN ? THRESH_OFF : THRESH;

  localparam logic [CNT_W-1:0]  ON_LVL   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0]  OFF_LVL  = CNT_W'(REL_LVL);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [HOLD_W:0]   HOLD_LIM = (HOLD_W + 1)'(HOLD);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_OCCUPIED = 2'd1;
  localparam logic [1:0] S_HOLDING  = 2'd2;

  logic [CHANNELS-1:0]              d_meta;
  logic [CHANNELS-1:0]              ds;
  logic [WIN_W-1:0]                 win_cnt;
  logic                             eval_c;
  logic [CHANNELS-1:0][CNT_W-1:0]   hit_cnt;
  logic [CHANNELS-1:0][CNT_W-1:0]   eval_cnt;
  logic [CHANNELS-1:0]              hit;
  logic [CHANNELS-1:0][1:0]         state;
  logic [CHANNELS-1:0][1:0]         state_nxt;
  logic [CHANNELS-1:0][HOLD_W-1:0]  hold_cnt;
  logic [CHANNELS-1:0][HOLD_W-1:0]  hold_nxt;
  logic [CHANNELS-1:0]              rise_nxt;
  logic [CHANNELS-1:0]              car_nxt;
  logic [HOLD_W:0]                  hold_inc;

  // Two-flop synchroniser for the asynchronous loop inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_meta <= '0;
      ds     <= '0;
    end else begin
      d_meta <= detect;
      ds     <= d_meta;
    end
  end

  // A clear on the final strobe discards that sample and suppresses the evaluation
  assign eval_c = sample_en && !clear && (win_cnt == WIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (clear || eval_c) begin
      win_cnt <= '0;
    end else if (sample_en) begin
      win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (clear || eval_c) begin
          hit_cnt[i] <= '0;
        end else if (sample_en && ds[i]) begin
          hit_cnt[i] <= hit_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Evaluation includes the sample taken on the evaluation edge itself
  always_comb begin
    eval_cnt = '0;
    hit      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      eval_cnt[i] = hit_cnt[i] + CNT_W'(ds[i]);
      if (state[i] == S_EMPTY) begin
        hit[i] = (eval_cnt[i] >= ON_LVL);
      end else begin
        hit[i] = (eval_cnt[i] >= OFF_LVL);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    rise_nxt  = '0;
    car_nxt   = '0;
    hold_inc  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hold_inc = (HOLD_W + 1)'(hold_cnt[i]) + (HOLD_W + 1)'(1);
      if (eval_c) begin
        case (state[i])
          S_EMPTY: begin
            if (hit[i]) begin
              state_nxt[i] = S_OCCUPIED;
              rise_nxt[i]  = 1'b1;
            end
          end
          S_OCCUPIED: begin
            if (!hit[i]) begin
              if (HOLD == 0) begin
                state_nxt[i] = S_EMPTY;
                hold_nxt[i]  = '0;
              end else begin
                state_nxt[i] = S_HOLDING;
                hold_nxt[i]  = HOLD_W'(1);
              end
            end
          end
          S_HOLDING: begin
            if (hit[i]) begin
              state_nxt[i] = S_OCCUPIED;
              hold_nxt[i]  = '0;
            end else if (hold_inc > HOLD_LIM) begin
              state_nxt[i] = S_EMPTY;
              hold_nxt[i]  = '0;
            end else begin
              hold_nxt[i]  = HOLD_W'(hold_inc);
            end
          end
          default: begin
            state_nxt[i] = S_EMPTY;
            hold_nxt[i]  = '0;
          end
        endcase
      end
      car_nxt[i] = (state_nxt[i] != S_EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car      <= '0;
      car_rise <= '0;
      win_done <= 1'b0;
    end else begin
      car      <= car_nxt;
      car_rise <= rise_nxt;
      win_done <= eval_c;
    end
  end

endmodule

// File: tb/tb_vehicle_detect_array.sv
// Scoreboard bench for vehicle_detect_array: two instances (HOLD=1 and HOLD=0) share stimulus.
module tb_vehicle_detect_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_en;
  logic       clear;
  logic [1:0] detect;
  logic [1:0] car_a, rise_a, car_b, rise_b;
  logic       done_a, done_b;

  int checks = 0;
  int errors = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic [3:0] exp_a, exp_b;

`ifdef VDET_HYST_EN
  localparam logic [3:0] W7_B = 4'b1100;
  localparam logic [3:0] W8_A = 4'b1100;
  localparam logic [1:0] CLR_CAR_A = 2'b11;
`else
  localparam logic [3:0] W7_B = 4'b1000;
  localparam logic [3:0] W8_A = 4'b1000;
  localparam logic [1:0] CLR_CAR_A = 2'b10;
`endif

  always #5 clk = ~clk;

  vehicle_detect_array #(
    .CHANNELS(2), .WINDOW(8), .THRESH(4), .THRESH_OFF(2), .HOLD(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .clear(clear),
    .detect(detect), .car(car_a), .car_rise(rise_a), .win_done(done_a)
  );

  vehicle_detect_array #(
    .CHANNELS(2), .WINDOW(8), .THRESH(4), .THRESH_OFF(2), .HOLD(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .clear(clear),
    .detect(detect), .car(car_b), .car_rise(rise_b), .win_done(done_b)
  );

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected {car, car_rise} whenever an evaluation is presented
  always @(negedge clk) begin
    if (prev_a) check("pulse_end_a", {done_a, |rise_a}, 2'b00);
    prev_a = done_a;
    if (done_a) begin
      done_a_cnt++;
      if (q_a.size() == 0) begin
        check("spurious_done_a", {1'b0, done_a}, 2'b00);
      end else begin
        exp_a = q_a.pop_front();
        check("car_a", car_a, exp_a[3:2]);
        check("rise_a", rise_a, exp_a[1:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (prev_b) check("pulse_end_b", {done_b, |rise_b}, 2'b00);
    prev_b = done_b;
    if (done_b) begin
      done_b_cnt++;
      if (q_b.size() == 0) begin
        check("spurious_done_b", {1'b0, done_b}, 2'b00);
      end else begin
        exp_b = q_b.pop_front();
        check("car_b", car_b, exp_b[3:2]);
        check("rise_b", rise_b, exp_b[1:0]);
      end
    end
  end

  // One window of 8 strobes; bit k of p0/p1 is sample k of lane 0/1
  task automatic run_window(input logic [7:0] p0, input logic [7:0] p1, input logic clr_last,
                            input logic push, input logic [3:0] ea, input logic [3:0] eb);
    if (push) begin
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      detect = {p1[k], p0[k]};
      repeat (2) @(negedge clk);
      sample_en = 1'b1;
      clear     = clr_last && (k == 7);
      @(negedge clk);
      sample_en = 1'b0;
      clear     = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0; detect = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_car_a", car_a, 2'b00);
    check("reset_rise_a", rise_a, 2'b00);
    check("reset_done_a", {1'b0, done_a}, 2'b00);
    check("reset_car_b", car_b, 2'b00);
    check("reset_done_b", {1'b0, done_b}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // expected encoding {car[1:0], car_rise[1:0]}
    run_window(8'hFF, 8'h00, 1'b0, 1'b1, 4'b0101, 4'b0101); // basic presence
    run_window(8'h00, 8'h07, 1'b0, 1'b1, 4'b0100, 4'b0000); // 3 of 8; hold-off / HOLD=0
    run_window(8'h00, 8'h87, 1'b0, 1'b1, 4'b1010, 4'b1010); // 4 of 8 incl last
    run_window(8'h0F, 8'h00, 1'b0, 1'b1, 4'b1101, 4'b0101);
    run_window(8'h00, 8'hF0, 1'b0, 1'b1, 4'b1100, 4'b1010); // holding -> occupied, no rise
    run_window(8'hFF, 8'hFF, 1'b0, 1'b1, 4'b1100, 4'b1101);
    run_window(8'h41, 8'hFF, 1'b0, 1'b1, 4'b1100, W7_B);    // 2 hits: release threshold
    run_window(8'h01, 8'hFF, 1'b0, 1'b1, W8_A, 4'b1000);    // 1 hit
    run_window(8'hFF, 8'h00, 1'b1, 1'b0, 4'b0000, 4'b0000); // clear on 8th strobe
    check("car_after_clear_a", car_a, CLR_CAR_A);
    check("car_after_clear_b", car_b, 2'b10);
    run_window(8'h00, 8'hFF, 1'b0, 1'b1, 4'b1000, 4'b1000); // counts restarted

    repeat (10) @(negedge clk);
    checks++;
    if (done_a_cnt != 9 || q_a.size() != 0) begin
      errors++;
      $display("FAIL done_count_a: got %0d evaluations %0d pending, expected 9 and 0",
               done_a_cnt, q_a.size());
    end
    checks++;
    if (done_b_cnt != 9 || q_b.size() != 0) begin
      errors++;
      $display("FAIL done_count_b: got %0d evaluations %0d pending, expected 9 and 0",
               done_b_cnt, q_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
